// File: rtl/ahb_lite_cmd_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_lite_cmd_master_if
//  Purpose  : Bundles the command/response handshake and the AHB-Lite
//             master-side bus signals of ahb_lite_cmd_master.
//  Ports    : none (signals only). Modports:
//               master - view of the command master (drives the AHB address
//                        and data phase, consumes commands and HREADY/HRESP/
//                        HRDATA, produces responses).
//               slave  - opposite view, used by the command source, the
//                        response sink and the AHB slave side.
//  Revision : 1.0 - initial release
// ============================================================================
interface ahb_lite_cmd_master_if;

    // Command side
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_wdata;

    // Response side
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // AHB-Lite master outputs
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;

    // AHB-Lite master inputs
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HREADY, HRESP, HRDATA
    );

endinterface : ahb_lite_cmd_master_if
`default_nettype wire

// File: rtl/ahb_lite_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_lite_cmd_master
//  Purpose  : Single-layer AHB-Lite initiator. Turns a valid/ready command
//             stream into pipelined NONSEQ SINGLE transfers (one per cycle,
//             overlapped address and data phases) and returns one response
//             pulse per command, in order. Handles write byte-lane
//             replication and read lane extraction.
//  Ports    : HCLK     - clock
//             HRESETn  - asynchronous active-low reset
//             bus      - ahb_lite_cmd_master_if.master:
//                          cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_size/
//                          cmd_wdata, rsp_valid/rsp_rdata/rsp_err,
//                          HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HMASTLOCK/
//                          HWDATA (out), HREADY/HRESP/HRDATA (in)
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_lite_cmd_master #(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  wire logic               HCLK,
    input  wire logic               HRESETn,
    ahb_lite_cmd_master_if.master   bus
);

    localparam logic [1:0] C_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] C_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] C_SIZE_BYTE     = 2'd0;
    localparam logic [1:0] C_SIZE_HALF     = 2'd1;
    localparam logic [1:0] C_SIZE_WORD     = 2'd2;

    // ------------------------------------------------------------------
    // A-slot: address phase currently on the bus
    // ------------------------------------------------------------------
    logic        a_cmd_q,   a_cmd_d;     // slot holds an accepted command
    logic        a_bad_q,   a_bad_d;     // command is illegal, no bus access
    logic [31:0] haddr_q,   haddr_d;
    logic [1:0]  htrans_q,  htrans_d;
    logic        hwrite_q,  hwrite_d;
    logic [1:0]  hsize_q,   hsize_d;
    logic [31:0] a_wdata_q, a_wdata_d;   // right-justified, placed on A->D

    // ------------------------------------------------------------------
    // D-slot: data phase currently on the bus
    // ------------------------------------------------------------------
    logic        d_valid_q, d_valid_d;
    logic        d_write_q, d_write_d;
    logic [1:0]  d_size_q,  d_size_d;
    logic [1:0]  d_lane_q,  d_lane_d;    // addr[1:0] of the data phase
    logic        d_bad_q,   d_bad_d;
    logic [31:0] hwdata_q,  hwdata_d;

    // ------------------------------------------------------------------
    // Response register
    // ------------------------------------------------------------------
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q,   rsp_err_d;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    logic        w_cmd_illegal;
    logic [31:0] w_placed_wdata;
    logic [31:0] w_rd_shifted;
    logic [31:0] w_rd_extracted;

    // Size 3 is reserved; halfwords and words must be naturally aligned.
    always_comb begin
        w_cmd_illegal = 1'b0;
        case (bus.cmd_size)
            C_SIZE_BYTE: w_cmd_illegal = 1'b0;
            C_SIZE_HALF: w_cmd_illegal = bus.cmd_addr[0];
            C_SIZE_WORD: w_cmd_illegal = (bus.cmd_addr[1:0] != 2'b00);
            default:     w_cmd_illegal = 1'b1;
        endcase
    end

    // Replicating the datum across all lanes makes the correct lane carry it
    // whatever addr[1:0] is, so no address-dependent shift is needed.
    always_comb begin
        w_placed_wdata = a_wdata_q;
        case (hsize_q)
            C_SIZE_BYTE: w_placed_wdata = {4{a_wdata_q[7:0]}};
            C_SIZE_HALF: w_placed_wdata = {2{a_wdata_q[15:0]}};
            default:     w_placed_wdata = a_wdata_q;
        endcase
    end

    assign w_rd_shifted = bus.HRDATA >> {d_lane_q, 3'b000};

    always_comb begin
        w_rd_extracted = w_rd_shifted;
        case (d_size_q)
            C_SIZE_BYTE: w_rd_extracted = {24'd0, w_rd_shifted[7:0]};
            C_SIZE_HALF: w_rd_extracted = {16'd0, w_rd_shifted[15:0]};
            default:     w_rd_extracted = w_rd_shifted;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic. Nothing moves unless HREADY is high, which keeps
    // every address-phase output and HWDATA stable across wait states.
    // ------------------------------------------------------------------
    always_comb begin
        a_cmd_d     = a_cmd_q;
        a_bad_d     = a_bad_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        a_wdata_d   = a_wdata_q;
        d_valid_d   = d_valid_q;
        d_write_d   = d_write_q;
        d_size_d    = d_size_q;
        d_lane_d    = d_lane_q;
        d_bad_d     = d_bad_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (bus.HREADY) begin
            // Data phase completes: emit its response.
            if (d_valid_q) begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = bus.HRESP | d_bad_q;
                rsp_rdata_d = (d_write_q || d_bad_q) ? 32'd0 : w_rd_extracted;
            end

            // A -> D
            d_valid_d = a_cmd_q;
            if (a_cmd_q) begin
                d_write_d = hwrite_q;
                d_size_d  = hsize_q;
                d_lane_d  = haddr_q[1:0];
                d_bad_d   = a_bad_q;
                if (hwrite_q && !a_bad_q) begin
                    hwdata_d = w_placed_wdata;
                end
            end

            // Command -> A. An empty advance only drops HTRANS to IDLE and
            // leaves the remaining address-phase outputs untouched.
            a_cmd_d  = bus.cmd_valid;
            htrans_d = C_HTRANS_IDLE;
            if (bus.cmd_valid) begin
                a_bad_d   = w_cmd_illegal;
                haddr_d   = bus.cmd_addr;
                hwrite_d  = bus.cmd_write;
                hsize_d   = bus.cmd_size;
                a_wdata_d = bus.cmd_wdata;
                htrans_d  = w_cmd_illegal ? C_HTRANS_IDLE : C_HTRANS_NONSEQ;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_cmd_q     <= 1'b0;
            a_bad_q     <= 1'b0;
            haddr_q     <= 32'd0;
            htrans_q    <= C_HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= 2'd0;
            a_wdata_q   <= 32'd0;
            d_valid_q   <= 1'b0;
            d_write_q   <= 1'b0;
            d_size_q    <= 2'd0;
            d_lane_q    <= 2'd0;
            d_bad_q     <= 1'b0;
            hwdata_q    <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            a_cmd_q     <= a_cmd_d;
            a_bad_q     <= a_bad_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            a_wdata_q   <= a_wdata_d;
            d_valid_q   <= d_valid_d;
            d_write_q   <= d_write_d;
            d_size_q    <= d_size_d;
            d_lane_q    <= d_lane_d;
            d_bad_q     <= d_bad_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Accepting exactly when the bus advances keeps the A-slot single-entry.
    assign bus.cmd_ready = bus.HREADY;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    assign bus.HADDR     = haddr_q;
    assign bus.HTRANS    = htrans_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HSIZE     = {1'b0, hsize_q};
    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = HPROT_VAL;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HWDATA    = hwdata_q;

endmodule : ahb_lite_cmd_master
`default_nettype wire

// File: doc/ahb_lite_cmd_master.md
Name: ahb_lite_cmd_master

Overview:
- Single-layer AHB-Lite initiator that converts a simple command/response interface into pipelined NONSEQ single transfers.
- Used by debug and bridge logic to read and write peripherals on the AHB-Lite fabric, such as the 7-segment/LED slaves.
- Sustains one transfer per cycle with overlapped address/data phases.
- Handles byte-lane placement for writes and lane extraction for reads.

Parameters:
- HPROT_VAL, 4'b0011, constant value driven on HPROT (non-cacheable, non-bufferable, privileged data access).

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset; asynchronous assert, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted on a rising edge when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- cmd_wdata  in  32  write data, right-justified.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  32  read data, right-justified, zero-extended; 0 for writes.
- rsp_err  out  1  slave ERROR response or illegal command.
- HADDR  out  32  address phase.
- HTRANS  out  2  IDLE (00) or NONSEQ (10) only.
- HWRITE  out  1  address phase.
- HSIZE  out  3  {1'b0, size}.
- HBURST  out  3  always 3'b000 (SINGLE).
- HPROT  out  4  HPROT_VAL.
- HMASTLOCK  out  1  always 0.
- HWDATA  out  32  data phase.
- HREADY  in  1  transfer-complete / bus-advance.
- HRESP  in  1  0 = OKAY, 1 = ERROR.
- HRDATA  in  32  read data.

Behaviour:
- Reset: HADDR=0, HTRANS=00, HWRITE=0, HSIZE=000, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Reset mid-operation: all in-flight transfers are discarded and no response is issued.
- Two-slot pipeline:
  - A-slot holds the registered address-phase outputs plus a flag `bad`.
  - D-slot holds write, size, addr[1:0], wdata and `bad` for the current data phase.
- Pipeline advance rule:
  - The pipeline advances only on an edge with HREADY=1: D <= A, and A <= accepted command or IDLE.
  - With HREADY=0, every address-phase output and HWDATA is held stable.
- cmd_ready = HREADY (combinational).
  - A command presented while HREADY=0 waits.
  - cmd_valid=0 at an advance loads IDLE: HTRANS=00, other outputs unchanged.
- Illegal command: cmd_size=3, or addr misaligned (size 1 with addr[0]=1; size 2 with addr[1:0]!=0).
  - It is accepted normally, but its A-slot drives HTRANS=00 with bad=1.
  - When its D-slot completes (HREADY=1) it produces rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - No bus access occurs, and response order is preserved.
- Write lane placement: HWDATA is loaded on the advance edge that moves the command A -> D.
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Read extraction: on D-slot completion, HRDATA is shifted right by 8*addr[1:0] and masked to size.
  - Example: byte at addr[1:0]=2 gives {24'b0, HRDATA[23:16]}.
  - Example: half at 2 gives {16'b0, HRDATA[31:16]}.
- Response timing:
  - On an edge where the D-slot is valid and HREADY=1, rsp_valid=1 is registered for exactly one cycle.
  - rsp_err = HRESP | bad; rsp_rdata as above, or 0 for writes.
  - rsp_valid is 0 in every other cycle.
- ERROR response:
  - The first ERROR cycle (HRESP=1, HREADY=0) only stalls.
  - The second cycle (HRESP=1, HREADY=1) completes with rsp_err=1.
  - The pipelined A-slot transfer is not cancelled and proceeds normally.
- Latency (zero-wait slave):
  - Command accepted at edge E0.
  - NONSEQ driven in cycle E0..E1.
  - Data phase in cycle E1..E2.
  - rsp_valid high in cycle E2..E3.
  - So latency is 3 cycles, throughput 1/cycle.
- Wait states: each HREADY=0 cycle in the data phase delays every later response by one cycle.

Test Plan:
- Reset HRESETn=0 with cmd_valid=1 -> HTRANS=00, rsp_valid=0, all outputs at reset values; after release, first NONSEQ appears one cycle after first accept.
- Word write addr 0x4000_0000 data 0x1234_5678, zero-wait -> HADDR=0x4000_0000, HTRANS=10, HSIZE=010, HWRITE=1, then HWDATA=0x1234_5678; rsp_valid=1, rsp_err=0 on cycle 3.
- Byte write addr 0x4000_0003 data 0xAB, then byte read same addr with HRDATA=0xCD00_0000 -> HWDATA=0xABAB_ABAB, HSIZE=000; rsp_rdata=0x0000_00CD.
- Four back-to-back reads (addr 0x0,0x4,0x8,0xC) with HREADY low 2 cycles during the 2nd data phase -> HTRANS=10 on consecutive cycles except the stall; HADDR=0x8 held during stall; 4 ordered responses.
- Two-cycle ERROR on a write followed by a pipelined read -> HADDR/HTRANS held during first ERROR cycle; rsp_err=1 for write, then read completes with rsp_err=0.
- Half write at addr 0x1 followed by word read at 0x4 -> no NONSEQ for 0x1 (HTRANS=00 that cycle); responses rsp_err=1 then rsp_err=0, in order.
